// File: rtl/cpu_memory_pkg.sv
// -----------------------------------------------------------------------------
// cpu_memory_pkg
// Shared address map, STATUS bit positions and an address decoder for the
// small CPU memory/peripheral block.
//
// Contents:
//   RAM_LAST, ADDR_OUT, ADDR_IN, ADDR_TIMER, ADDR_STATUS : 4-bit address map
//   STATUS_WRAP_BIT, STATUS_CHANGE_BIT                   : STATUS bit indices
//   region_e / decodeRegion()                            : address -> region
// -----------------------------------------------------------------------------
package cpu_memory_pkg;

  // Address map: 0x0..RAM_LAST is RAM, the top four addresses are registers.
  localparam logic [3:0] RAM_LAST    = 4'hB;
  localparam logic [3:0] ADDR_OUT    = 4'hC;
  localparam logic [3:0] ADDR_IN     = 4'hD;
  localparam logic [3:0] ADDR_TIMER  = 4'hE;
  localparam logic [3:0] ADDR_STATUS = 4'hF;

  // STATUS register bit positions.
  localparam int STATUS_WRAP_BIT   = 0;
  localparam int STATUS_CHANGE_BIT = 1;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_OUT,
    REGION_IN,
    REGION_TIMER,
    REGION_STATUS
  } region_e;

  // Maps a CPU address onto the peripheral it selects. Anything not in the
  // register window is RAM.
  function automatic region_e decodeRegion(input logic [3:0] addr);
    region_e region;
    region = REGION_RAM;
    case (addr)
      ADDR_OUT:    region = REGION_OUT;
      ADDR_IN:     region = REGION_IN;
      ADDR_TIMER:  region = REGION_TIMER;
      ADDR_STATUS: region = REGION_STATUS;
      default:     region = REGION_RAM;
    endcase
    return region;
  endfunction

endpackage

// File: rtl/cpu_memory_timer.sv
// -----------------------------------------------------------------------------
// cpu_memory_timer
// 8-bit up counter advanced once every PRESCALE clocks, with a sticky wrap
// flag that forms STATUS bit 0.
//
// Ports:
//   clk          in   clock, all updates on posedge
//   reset_n      in   synchronous active-low reset
//   load_i       in   CPU write to the TIMER address this cycle
//   loadValue_i  in   value loaded into the counter on load_i
//   flagClear_i  in   W1C request for the wrap flag
//   count_o      out  current counter value
//   wrapFlag_o   out  sticky wrap flag
// -----------------------------------------------------------------------------
module cpu_memory_timer
  import cpu_memory_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] loadValue_i,
  input  logic       flagClear_i,
  output logic [7:0] count_o,
  output logic       wrapFlag_o
);

  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

  logic [7:0] count_q, count_d;
  logic [7:0] presc_q, presc_d;
  logic       wrapFlag_q, wrapFlag_d;
  logic       wrapEvent;

  // Next-state for counter and prescaler. A CPU load wins over a pending
  // increment and restarts the prescale period from zero. The wrap event is
  // raised on the same edge the counter rolls from 0xFF to 0x00, and a set
  // overrides a simultaneous W1C clear.
  always_comb begin
    count_d   = count_q;
    presc_d   = presc_q;
    wrapEvent = 1'b0;
    if (load_i) begin
      count_d = loadValue_i;
      presc_d = 8'h00;
    end else if (presc_q == PRESC_MAX) begin
      presc_d   = 8'h00;
      count_d   = count_q + 8'h01;
      wrapEvent = (count_q == 8'hFF);
    end else begin
      presc_d = presc_q + 8'h01;
    end
    wrapFlag_d = wrapEvent | (wrapFlag_q & ~flagClear_i);
  end

  // State registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q    <= 8'h00;
      presc_q    <= 8'h00;
      wrapFlag_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      presc_q    <= presc_d;
      wrapFlag_q <= wrapFlag_d;
    end
  end

  assign count_o    = count_q;
  assign wrapFlag_o = wrapFlag_q;

endmodule

// File: rtl/cpu_memory.sv
// -----------------------------------------------------------------------------
// cpu_memory
// 16-byte CPU address space: 12 bytes of RAM plus an output port, a
// synchronized input port, a prescaled timer and a STATUS register. A
// separate loader port can fill RAM, including while the CPU is in reset.
//
// Ports:
//   clk          in   clock
//   reset_n      in   synchronous active-low reset
//   mem_address  in   CPU address
//   mem_data_r   out  combinational read data for mem_address
//   mem_data_w   in   CPU write data
//   mem_we       in   CPU write strobe
//   load_we      in   loader write strobe (RAM only, has priority)
//   load_addr    in   loader address
//   load_data    in   loader data
//   port_in      in   asynchronous input port
//   port_out     out  registered output port
//   timer_irq    out  STATUS bit 0 (timer wrap)
// -----------------------------------------------------------------------------
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] mem_address,
  output logic [7:0] mem_data_r,
  input  logic [7:0] mem_data_w,
  input  logic       mem_we,
  input  logic       load_we,
  input  logic [3:0] load_addr,
  input  logic [7:0] load_data,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       timer_irq
);

  logic [7:0] ramMem_q [12];
  logic [7:0] portOut_q, portOut_d;
  logic [7:0] sync1_q, sync2_q, prevIn_q;
  logic       changeFlag_q, changeFlag_d;
  logic       cpuWrite;
  region_e    cpuRegion;
  logic [7:0] timerCount;
  logic       wrapFlag;
  logic       timerLoad;
  logic       wrapClear;
  logic       changeEvent;

  // A CPU write only lands when the CPU is out of reset and the loader is
  // idle; any loader strobe drops the CPU write regardless of addresses.
  assign cpuRegion = decodeRegion(mem_address);
  assign cpuWrite  = mem_we & ~load_we & reset_n;
  assign timerLoad = cpuWrite & (cpuRegion == REGION_TIMER);
  assign wrapClear = cpuWrite & (cpuRegion == REGION_STATUS)
                     & mem_data_w[STATUS_WRAP_BIT];

  cpu_memory_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (timerLoad),
    .loadValue_i (mem_data_w),
    .flagClear_i (wrapClear),
    .count_o     (timerCount),
    .wrapFlag_o  (wrapFlag)
  );

  // RAM has no reset so a preloaded program survives reset pulses. The
  // loader is deliberately outside the reset condition; loader addresses
  // above RAM_LAST are simply discarded.
  always_ff @(posedge clk) begin
    if (load_we && (load_addr <= RAM_LAST)) begin
      ramMem_q[load_addr] <= load_data;
    end else if (cpuWrite && (cpuRegion == REGION_RAM)) begin
      ramMem_q[mem_address] <= mem_data_w;
    end
  end

  // Output port next-state and input-change sticky flag. A change seen on
  // the synchronizer output beats a same-cycle W1C of that bit.
  always_comb begin
    portOut_d = portOut_q;
    if (cpuWrite && (cpuRegion == REGION_OUT)) begin
      portOut_d = mem_data_w;
    end
    changeEvent  = (sync2_q != prevIn_q);
    changeFlag_d = changeEvent
                   | (changeFlag_q
                      & ~(cpuWrite && (cpuRegion == REGION_STATUS)
                          && mem_data_w[STATUS_CHANGE_BIT]));
  end

  // Output port, two-flop synchronizer for port_in, the previous-value
  // register used for change detection and the change flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      portOut_q    <= 8'h00;
      sync1_q      <= 8'h00;
      sync2_q      <= 8'h00;
      prevIn_q     <= 8'h00;
      changeFlag_q <= 1'b0;
    end else begin
      portOut_q    <= portOut_d;
      sync1_q      <= port_in;
      sync2_q      <= sync1_q;
      prevIn_q     <= sync2_q;
      changeFlag_q <= changeFlag_d;
    end
  end

  // Zero-latency read mux; reads never modify state.
  always_comb begin
    mem_data_r = 8'h00;
    case (cpuRegion)
      REGION_RAM:    mem_data_r = ramMem_q[mem_address];
      REGION_OUT:    mem_data_r = portOut_q;
      REGION_IN:     mem_data_r = sync2_q;
      REGION_TIMER:  mem_data_r = timerCount;
      REGION_STATUS: mem_data_r = {6'b000000, changeFlag_q, wrapFlag};
      default:       mem_data_r = 8'h00;
    endcase
  end

  assign port_out  = portOut_q;
  assign timer_irq = wrapFlag;

endmodule

// File: tb/tb_cpu_memory.sv
// -----------------------------------------------------------------------------
// tb_cpu_memory
// Directed and randomized checks of cpu_memory against a behavioural model
// of the address map, timer, input port and STATUS register.
// -----------------------------------------------------------------------------
module tb_cpu_memory;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] mem_address;
  logic [7:0] mem_data_r;
  logic [7:0] mem_data_w;
  logic       mem_we;
  logic       load_we;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       timer_irq;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state.
  logic [7:0] mRam [12];
  logic [7:0] mPortOut;
  logic [7:0] mTimer;
  int         mTicks;
  logic [1:0] mStatus;
  logic [7:0] mIn [3];

  cpu_memory #(
    .PRESCALE (P)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_address (mem_address),
    .mem_data_r  (mem_data_r),
    .mem_data_w  (mem_data_w),
    .mem_we      (mem_we),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .port_in     (port_in),
    .port_out    (port_out),
    .timer_irq   (timer_irq)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Initial RAM pattern written by the loader.
  function automatic logic [7:0] preloadVal(input int i);
    return 8'h5A ^ 8'(i * 8'h11);
  endfunction

  // Model of one clock edge using the inputs currently driven. The timer is
  // tracked as "edges since load"; it steps on every P-th edge. The input
  // port history holds port_in for the last three edges: [1] is what the CPU
  // sees, [2] the value one edge older.
  task automatic modelStep();
    logic       cpuW;
    logic       wrapEv;
    logic       changeEv;
    logic [1:0] clr;
    cpuW = mem_we && !load_we && reset_n;
    if (load_we && (load_addr < 4'd12)) mRam[load_addr] = load_data;
    if (!reset_n) begin
      mPortOut = 8'h00;
      mTimer   = 8'h00;
      mTicks   = 0;
      mStatus  = 2'b00;
      mIn[0]   = 8'h00;
      mIn[1]   = 8'h00;
      mIn[2]   = 8'h00;
    end else begin
      if (cpuW && (mem_address < 4'd12)) mRam[mem_address] = mem_data_w;
      wrapEv   = 1'b0;
      changeEv = (mIn[1] != mIn[2]);
      if (cpuW && (mem_address == 4'hE)) begin
        mTimer = mem_data_w;
        mTicks = 0;
      end else begin
        mTicks++;
        if ((mTicks % P) == 0) begin
          mTimer = mTimer + 8'd1;
          if (mTimer == 8'h00) wrapEv = 1'b1;
        end
      end
      clr     = (cpuW && (mem_address == 4'hF)) ? mem_data_w[1:0] : 2'b00;
      mStatus = (mStatus & ~clr) | {changeEv, wrapEv};
      if (cpuW && (mem_address == 4'hC)) mPortOut = mem_data_w;
      mIn[2] = mIn[1];
      mIn[1] = mIn[0];
      mIn[0] = port_in;
    end
  endtask

  function automatic logic [7:0] modelRead(input logic [3:0] a);
    if (a < 4'd12)  return mRam[a];
    if (a == 4'hC)  return mPortOut;
    if (a == 4'hD)  return mIn[1];
    if (a == 4'hE)  return mTimer;
    return {6'b000000, mStatus};
  endfunction

  // Advance one posedge with the currently driven inputs, then settle.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Combinational read at an address within the current cycle.
  task automatic readAt(input logic [3:0] a, output logic [7:0] d);
    mem_address = a;
    #1;
    d = mem_data_r;
  endtask

  task automatic idleInputs();
    mem_we    = 1'b0;
    load_we   = 1'b0;
    mem_data_w = 8'h00;
    load_addr = 4'h0;
    load_data = 8'h00;
  endtask

  initial begin
    logic [7:0] rd;
    reset_n     = 1'b0;
    mem_address = 4'h0;
    port_in     = 8'h00;
    idleInputs();
    applyStimulus();
    applyStimulus();

    // Preload all RAM with the CPU held in reset; address 3 gets 0x8A.
    for (int i = 0; i < 12; i++) begin
      load_we   = 1'b1;
      load_addr = 4'(i);
      load_data = (i == 3) ? 8'h8A : preloadVal(i);
      applyStimulus();
    end
    idleInputs();

    // Reset state.
    readAt(4'hC, rd); checkOutput("reset_out", rd, 8'h00);
    readAt(4'hD, rd); checkOutput("reset_in", rd, 8'h00);
    readAt(4'hE, rd); checkOutput("reset_timer", rd, 8'h00);
    readAt(4'hF, rd); checkOutput("reset_status", rd, 8'h00);
    checkOutput("reset_port_out", port_out, 8'h00);
    checkOutput("reset_irq", {7'b0, timer_irq}, 8'h00);

    // Preloaded byte visible in the same cycle reset is released, and
    // retained across another reset pulse.
    reset_n = 1'b1;
    readAt(4'h3, rd); checkOutput("preload_read", rd, 8'h8A);
    applyStimulus();
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1;
    readAt(4'h3, rd); checkOutput("preload_after_reset", rd, 8'h8A);
    checkOutput("irq_after_reset", {7'b0, timer_irq}, 8'h00);

    // Output port write; IN port ignores writes.
    mem_we = 1'b1; mem_address = 4'hC; mem_data_w = 8'h05;
    applyStimulus();
    mem_we = 1'b0;
    checkOutput("port_out_write", port_out, 8'h05);
    readAt(4'hC, rd); checkOutput("out_readback", rd, 8'h05);
    mem_we = 1'b1; mem_address = 4'hD; mem_data_w = 8'hFF;
    applyStimulus();
    mem_we = 1'b0;
    readAt(4'hD, rd); checkOutput("in_write_ignored", rd, 8'h00);

    // Timer load, increment after P edges and wrap.
    mem_we = 1'b1; mem_address = 4'hE; mem_data_w = 8'hFE;
    applyStimulus();
    mem_we = 1'b0;
    readAt(4'hE, rd); checkOutput("timer_load", rd, 8'hFE);
    for (int i = 0; i < 3; i++) applyStimulus();
    readAt(4'hE, rd); checkOutput("timer_before_step", rd, 8'hFE);
    applyStimulus();
    readAt(4'hE, rd); checkOutput("timer_ff", rd, 8'hFF);
    for (int i = 0; i < 3; i++) applyStimulus();
    readAt(4'hF, rd); checkOutput("status_before_wrap", rd, 8'h00);
    applyStimulus();
    readAt(4'hE, rd); checkOutput("timer_wrap", rd, 8'h00);
    readAt(4'hF, rd); checkOutput("status_wrap", rd, 8'h01);
    checkOutput("irq_wrap", {7'b0, timer_irq}, 8'h01);
    mem_we = 1'b1; mem_address = 4'hF; mem_data_w = 8'h01;
    applyStimulus();
    mem_we = 1'b0;
    readAt(4'hF, rd); checkOutput("status_w1c", rd, 8'h00);
    checkOutput("irq_cleared", {7'b0, timer_irq}, 8'h00);

    // Input port: two-edge latency, change flag, set beats W1C.
    port_in = 8'h3C;
    applyStimulus();
    readAt(4'hD, rd); checkOutput("in_lag1", rd, 8'h00);
    applyStimulus();
    readAt(4'hD, rd); checkOutput("in_lag2", rd, 8'h3C);
    readAt(4'hF, rd); checkOutput("status_pre_change", rd, 8'h00);
    mem_we = 1'b1; mem_address = 4'hF; mem_data_w = 8'h02;
    applyStimulus();
    readAt(4'hF, rd); checkOutput("change_set_wins", rd, 8'h02);
    mem_we = 1'b1; mem_address = 4'hF; mem_data_w = 8'h02;
    applyStimulus();
    mem_we = 1'b0;
    readAt(4'hF, rd); checkOutput("change_w1c", rd, 8'h00);

    // Loader and CPU write in the same cycle: loader wins, CPU dropped.
    load_we = 1'b1; load_addr = 4'h1; load_data = 8'h11;
    mem_we  = 1'b1; mem_address = 4'h2; mem_data_w = 8'h22;
    applyStimulus();
    idleInputs();
    readAt(4'h1, rd); checkOutput("collide_loader", rd, 8'h11);
    readAt(4'h2, rd); checkOutput("collide_cpu_dropped", rd, preloadVal(2));

    // Loader to a register address is ignored.
    load_we = 1'b1; load_addr = 4'hC; load_data = 8'h99;
    applyStimulus();
    idleInputs();
    checkOutput("loader_reg_ignored", port_out, 8'h05);

    // Make STATUS non-zero, then reset with a coincident CPU write.
    port_in = 8'h55;
    for (int i = 0; i < 4; i++) applyStimulus();
    reset_n = 1'b0;
    mem_we = 1'b1; mem_address = 4'hC; mem_data_w = 8'hAA;
    applyStimulus();
    reset_n = 1'b1;
    mem_we  = 1'b0;
    checkOutput("reset_aborts_write", port_out, 8'h00);
    readAt(4'hE, rd); checkOutput("reset_timer2", rd, 8'h00);
    readAt(4'hF, rd); checkOutput("reset_status2", rd, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset_n     = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      mem_we      = ($urandom_range(0, 99) < 40);
      load_we     = ($urandom_range(0, 99) < 10);
      mem_address = 4'($urandom_range(0, 15));
      mem_data_w  = 8'($urandom);
      if (mem_address == 4'hE) mem_data_w = 8'hF0 | 8'($urandom_range(0, 15));
      load_addr   = (load_we && mem_we) ? 4'($urandom_range(0, 11))
                                        : 4'($urandom_range(0, 15));
      load_data   = 8'($urandom);
      if ($urandom_range(0, 99) < 20) port_in = 8'($urandom);
      applyStimulus();
      checkOutput("rand_read", mem_data_r, modelRead(mem_address));
      checkOutput("rand_port_out", port_out, mPortOut);
      checkOutput("rand_irq", {7'b0, timer_irq}, {7'b0, mStatus[0]});
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
